// File: rtl/serial_adder_if.sv
// Handshake and operand/result bundle for serial_adder.
// The master drives the request; the slave (the adder) returns the result.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
);
    logic             START;
    logic             SUB;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [WIDTH-1:0] SUM;
    logic             C_OUT;
    logic             OVF;
    logic             BUSY;
    logic             DONE;

    modport master (
        output START, SUB, A, B,
        input  SUM, C_OUT, OVF, BUSY, DONE
    );

    modport slave (
        input  START, SUB, A, B,
        output SUM, C_OUT, OVF, BUSY, DONE
    );
endinterface

// File: rtl/serial_adder.sv
// Chunk-serial add/subtract with START/BUSY/DONE handshake, CHUNK bits per clock.
// Optional signed saturation of SUM on overflow: define SERIAL_ADDER_SAT_EN.
module serial_adder #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CHUNK = 2
) (
    input  logic          CLK,
    input  logic          RST,
    serial_adder_if.slave bus
);
    localparam int unsigned N     = WIDTH / CHUNK;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;

    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
        $error("serial_adder: WIDTH must be >= 2 and CHUNK must divide WIDTH");
    end
    if ($bits(bus.A) != WIDTH) begin : g_if_check
        $error("serial_adder: interface WIDTH does not match module WIDTH");
    end

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t             state, state_next;
    logic [WIDTH-1:0]   a_reg, a_next;
    logic [WIDTH-1:0]   b_reg, b_next;
    logic               carry_reg, carry_next;
    logic [WIDTH-1:0]   acc_reg, acc_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic [WIDTH-1:0]   sum_reg, sum_next;
    logic               c_out_reg, c_out_next;
    logic               ovf_reg, ovf_next;

    logic [CHUNK-1:0]   chunk_sum;
    logic               chunk_carry;
    logic               c_msb_in;
    logic               ripple_c;
    logic [WIDTH-1:0]   acc_shift;
    logic [WIDTH-1:0]   result;
    logic               last_chunk;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= ST_IDLE;
            a_reg     <= '0;
            b_reg     <= '0;
            carry_reg <= 1'b0;
            acc_reg   <= '0;
            cnt       <= '0;
            sum_reg   <= '0;
            c_out_reg <= 1'b0;
            ovf_reg   <= 1'b0;
        end else begin
            state     <= state_next;
            a_reg     <= a_next;
            b_reg     <= b_next;
            carry_reg <= carry_next;
            acc_reg   <= acc_next;
            cnt       <= cnt_next;
            sum_reg   <= sum_next;
            c_out_reg <= c_out_next;
            ovf_reg   <= ovf_next;
        end
    end

    // Bit-level ripple inside the chunk so the carry into the MSB is visible for OVF.
    always_comb begin
        chunk_sum = '0;
        c_msb_in  = 1'b0;
        ripple_c  = carry_reg;
        for (int unsigned i = 0; i < CHUNK; i++) begin
            chunk_sum[i] = a_reg[i] ^ b_reg[i] ^ ripple_c;
            c_msb_in     = ripple_c;
            ripple_c     = (a_reg[i] & b_reg[i]) | (ripple_c & (a_reg[i] ^ b_reg[i]));
        end
        chunk_carry = ripple_c;
    end

    // New chunk enters at the top; after N chunks the LSB chunk has reached bit 0.
    assign acc_shift  = (acc_reg >> CHUNK) | (WIDTH'(chunk_sum) << (WIDTH - CHUNK));
    assign last_chunk = (cnt == CNT_W'(N - 1));

    always_comb begin
        result = acc_shift;
`ifdef SERIAL_ADDER_SAT_EN
        if (c_msb_in ^ chunk_carry) begin
            result = acc_shift[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                        : {1'b1, {(WIDTH-1){1'b0}}};
        end
`endif
    end

    always_comb begin
        state_next = state;
        a_next     = a_reg;
        b_next     = b_reg;
        carry_next = carry_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt;
        sum_next   = sum_reg;
        c_out_next = c_out_reg;
        ovf_next   = ovf_reg;

        case (state)
            ST_IDLE, ST_DONE: begin
                if (bus.START) begin
                    a_next     = bus.A;
                    b_next     = bus.SUB ? ~bus.B : bus.B;
                    carry_next = bus.SUB;
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                a_next     = a_reg >> CHUNK;
                b_next     = b_reg >> CHUNK;
                carry_next = chunk_carry;
                acc_next   = acc_shift;
                cnt_next   = cnt + CNT_W'(1);
                if (last_chunk) begin
                    sum_next   = result;
                    c_out_next = chunk_carry;
                    ovf_next   = c_msb_in ^ chunk_carry;
                    state_next = ST_DONE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    assign bus.SUM   = sum_reg;
    assign bus.C_OUT = c_out_reg;
    assign bus.OVF   = ovf_reg;
    assign bus.BUSY  = (state == ST_RUN);
    assign bus.DONE  = (state == ST_DONE);
endmodule

// File: tb/tb_serial_adder.sv
// Directed-vector bench for serial_adder at WIDTH=8, CHUNK=2 (four chunks per operation).
// Expected sums follow SERIAL_ADDER_SAT_EN when the bench is built with it.
module tb_serial_adder;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CHUNK = 2;
    localparam int          NCH   = WIDTH / CHUNK;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    int   checks = 0;
    int   errors = 0;

    serial_adder_if #(.WIDTH(WIDTH)) bus ();

    serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    // Entered at a negedge; launches one request and returns at the negedge where DONE is seen
    // (or after a bounded number of cycles). Reports BUSY cycles, edges to DONE and mid-run SUM.
    task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic sub,
                         output int busy_cycles, output int latency, output logic [7:0] sum_mid);
        bus.A     = a;
        bus.B     = b;
        bus.SUB   = sub;
        bus.START = 1'b1;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        busy_cycles = 0;
        latency     = -1;
        sum_mid     = 'x;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (k == 2) sum_mid = bus.SUM;
            if (bus.DONE === 1'b1) begin
                latency = k - 1;
                break;
            end
            if (bus.BUSY === 1'b1) busy_cycles++;
        end
    endtask

    task automatic test_reset();
        RST       = 1'b1;
        bus.START = 1'b1;
        bus.A     = 8'hAA;
        bus.B     = 8'h55;
        bus.SUB   = 1'b0;
        repeat (3) @(negedge CLK);
        checks++;
        if ({bus.BUSY, bus.DONE, bus.C_OUT, bus.OVF, bus.SUM} !== 12'h000) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b c=%b ovf=%b sum=%h, want all 0",
                     bus.BUSY, bus.DONE, bus.C_OUT, bus.OVF, bus.SUM);
        end
        bus.START = 1'b0;
        RST       = 1'b0;
        @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: busy=%b want 0", bus.BUSY);
        end
    endtask

    task automatic test_add();
        int busy, lat;
        logic [7:0] mid;
        do_op(8'd100, 8'd27, 1'b0, busy, lat, mid);
        checks++;
        if (busy !== NCH || lat !== NCH) begin
            errors++;
            $display("FAIL add_timing: busy=%0d latency=%0d, want %0d and %0d", busy, lat, NCH, NCH);
        end
        checks++;
        if (mid !== 8'h00) begin
            errors++;
            $display("FAIL add_sum_hold: mid-run SUM=%h want 00", mid);
        end
        checks++;
        if (bus.SUM !== 8'h7F || bus.C_OUT !== 1'b0 || bus.OVF !== 1'b0 || bus.BUSY !== 1'b0) begin
            errors++;
            $display("FAIL add_100_27: sum=%h c=%b ovf=%b busy=%b, want 7F 0 0 0",
                     bus.SUM, bus.C_OUT, bus.OVF, bus.BUSY);
        end
        // DONE is held while no new START arrives
        repeat (3) @(negedge CLK);
        checks++;
        if (bus.DONE !== 1'b1 || bus.SUM !== 8'h7F) begin
            errors++;
            $display("FAIL done_hold: done=%b sum=%h, want 1 7F", bus.DONE, bus.SUM);
        end
    endtask

    task automatic test_back_to_back();
        int busy, lat;
        logic [7:0] mid;
        do_op(8'd200, 8'd100, 1'b0, busy, lat, mid);
        checks++;
        if (bus.SUM !== 8'h2C || bus.C_OUT !== 1'b1 || bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL add_200_100: sum=%h c=%b ovf=%b, want 2C 1 0", bus.SUM, bus.C_OUT, bus.OVF);
        end
        do_op(8'd5, 8'd7, 1'b1, busy, lat, mid);
        checks++;
        if (busy !== NCH || lat !== NCH || mid !== 8'h2C) begin
            errors++;
            $display("FAIL b2b_timing: busy=%0d latency=%0d mid=%h, want %0d %0d 2C", busy, lat, mid, NCH, NCH);
        end
        checks++;
        if (bus.SUM !== 8'hFE || bus.C_OUT !== 1'b0 || bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL sub_5_7: sum=%h c=%b ovf=%b, want FE 0 0", bus.SUM, bus.C_OUT, bus.OVF);
        end
    endtask

    task automatic test_overflow();
        int busy, lat;
        logic [7:0] mid;
        logic [7:0] exp_pos, exp_neg, exp_dbl;
`ifdef SERIAL_ADDER_SAT_EN
        exp_pos = 8'h7F;
        exp_neg = 8'h80;
        exp_dbl = 8'h80;
`else
        exp_pos = 8'h80;
        exp_neg = 8'h7F;
        exp_dbl = 8'h00;
`endif
        do_op(8'h7F, 8'h01, 1'b0, busy, lat, mid);
        checks++;
        if (bus.SUM !== exp_pos || bus.C_OUT !== 1'b0 || bus.OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf_7F_plus_1: sum=%h c=%b ovf=%b, want %h 0 1", bus.SUM, bus.C_OUT, bus.OVF, exp_pos);
        end
        do_op(8'h80, 8'h01, 1'b1, busy, lat, mid);
        checks++;
        if (bus.SUM !== exp_neg || bus.C_OUT !== 1'b1 || bus.OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf_80_minus_1: sum=%h c=%b ovf=%b, want %h 1 1", bus.SUM, bus.C_OUT, bus.OVF, exp_neg);
        end
        do_op(8'h80, 8'h80, 1'b0, busy, lat, mid);
        checks++;
        if (bus.SUM !== exp_dbl || bus.C_OUT !== 1'b1 || bus.OVF !== 1'b1) begin
            errors++;
            $display("FAIL ovf_80_plus_80: sum=%h c=%b ovf=%b, want %h 1 1", bus.SUM, bus.C_OUT, bus.OVF, exp_dbl);
        end
    endtask

    task automatic test_wrap();
        int busy, lat;
        logic [7:0] mid;
        do_op(8'hFF, 8'h01, 1'b0, busy, lat, mid);
        checks++;
        if (bus.SUM !== 8'h00 || bus.C_OUT !== 1'b1 || bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL wrap_FF_plus_1: sum=%h c=%b ovf=%b, want 00 1 0", bus.SUM, bus.C_OUT, bus.OVF);
        end
        do_op(8'h33, 8'h33, 1'b1, busy, lat, mid);
        checks++;
        if (bus.SUM !== 8'h00 || bus.C_OUT !== 1'b1 || bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL sub_equal: sum=%h c=%b ovf=%b, want 00 1 0", bus.SUM, bus.C_OUT, bus.OVF);
        end
    endtask

    task automatic test_start_while_busy();
        int lat;
        bus.A     = 8'h01;
        bus.B     = 8'h01;
        bus.SUB   = 1'b0;
        bus.START = 1'b1;
        @(posedge CLK);
        #1;
        bus.A   = 8'hFF;
        bus.B   = 8'hFF;
        bus.SUB = 1'b1;
        lat     = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge CLK);
            if (k == 3) bus.START = 1'b0;
            if (bus.DONE === 1'b1) begin
                lat = k - 1;
                break;
            end
        end
        checks++;
        if (lat !== NCH || bus.SUM !== 8'h02 || bus.C_OUT !== 1'b0 || bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL start_ignored: latency=%0d sum=%h c=%b ovf=%b, want %0d 02 0 0",
                     lat, bus.SUM, bus.C_OUT, bus.OVF, NCH);
        end
        bus.START = 1'b0;
    endtask

    task automatic test_reset_mid_run();
        int busy, lat;
        logic [7:0] mid;
        bus.A     = 8'h10;
        bus.B     = 8'h20;
        bus.SUB   = 1'b0;
        bus.START = 1'b1;
        @(posedge CLK);
        #1 bus.START = 1'b0;
        @(posedge CLK);
        #1;
        RST       = 1'b1;
        bus.START = 1'b1;
        @(negedge CLK);
        checks++;
        if (bus.BUSY !== 1'b1) begin
            errors++;
            $display("FAIL pre_abort_busy: busy=%b want 1", bus.BUSY);
        end
        @(negedge CLK);
        checks++;
        if ({bus.BUSY, bus.DONE, bus.C_OUT, bus.OVF, bus.SUM} !== 12'h000) begin
            errors++;
            $display("FAIL abort_outputs: busy=%b done=%b c=%b ovf=%b sum=%h, want all 0",
                     bus.BUSY, bus.DONE, bus.C_OUT, bus.OVF, bus.SUM);
        end
        RST       = 1'b0;
        bus.START = 1'b0;
        do_op(8'd3, 8'd4, 1'b0, busy, lat, mid);
        checks++;
        if (busy !== NCH || lat !== NCH || bus.SUM !== 8'h07 || bus.C_OUT !== 1'b0 || bus.OVF !== 1'b0) begin
            errors++;
            $display("FAIL after_abort_3_4: busy=%0d latency=%0d sum=%h c=%b ovf=%b, want %0d %0d 07 0 0",
                     busy, lat, bus.SUM, bus.C_OUT, bus.OVF, NCH, NCH);
        end
    endtask

    initial begin
        bus.START = 1'b0;
        bus.SUB   = 1'b0;
        bus.A     = '0;
        bus.B     = '0;
        @(negedge CLK);
        test_reset();
        test_add();
        test_back_to_back();
        test_overflow();
        test_wrap();
        test_start_while_busy();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
